// File: rtl/rpc_flow_steering_pkg.sv
// Shared NIC types for the TX flow-steering stage.
// Flow ids are carried at their widest; ports narrow them.
package nic_defs;

  localparam int FLOW_W = 8;

  typedef logic [FLOW_W-1:0] FlowId;
  typedef logic [15:0] ConnId;

  typedef enum logic {
    SteerRR    = 1'b0,
    SteerTable = 1'b1
  } SteerMode;

  typedef struct packed {
    logic [15:0] rpc_id;
    logic [31:0] arg;
  } RpcIf;

  typedef struct packed {
    RpcIf  rpc;
    FlowId flow;
  } SteeredRpc;

endpackage

// File: rtl/rpc_flow_steering_sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Occupancy is exported so the owner can plan ahead.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [LOG_DEPTH:0]    count
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr;
  logic [LOG_DEPTH-1:0]  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == {1'b1, {LOG_DEPTH{1'b0}}});
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rpc_flow_steering.sv
// TX flow steering: pick a flow per RPC, buffer, and feed the
// CCI-P transmitter only while it can take data.
module rpc_flow_steering
  import nic_defs::*;
#(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LCONN_TBL         = 3,
  parameter int LFIFO_DEPTH       = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic                         tbl_wr_en,
  input  logic [LCONN_TBL-1:0]         tbl_wr_idx,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] tbl_wr_flow,
  input  RpcIf                         rpc_in,
  input  logic                         rpc_in_valid,
  input  ConnId                        rpc_conn_id_in,
  output logic                         rpc_in_ready,
  input  logic                         ccip_tx_ready,
  output RpcIf                         rpc_out,
  output logic                         rpc_out_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  output logic [31:0]                  stat_accepted,
  output logic [31:0]                  stat_dropped
);

  localparam int TBL_N = 1 << LCONN_TBL;
  localparam int CW    = LFIFO_DEPTH + 1;
  localparam logic [CW-1:0] FULL_OCC = {1'b1, {LFIFO_DEPTH{1'b0}}};

  typedef logic [LMAX_NUM_OF_FLOWS-1:0] flow_t;

  SteerMode  mode_e;
  flow_t     tbl [TBL_N];
  flow_t     rr_ptr;
  flow_t     rr_flow;
  flow_t     tbl_flow;
  flow_t     steer_flow;
  logic      ready_q;
  logic      accept;
  SteeredRpc s1_q;
  logic      s1_valid;
  SteeredRpc fifo_rdata;
  SteeredRpc out_data;
  logic      fifo_full;
  logic      fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_d;
  logic      can_pop;
  logic      bypass;
  logic      fifo_pop;
  logic      fifo_push;
  logic      pop_any;
  logic      unused;

  assign mode_e       = SteerMode'(mode);
  assign rpc_in_ready = ready_q;
  assign accept       = start && rpc_in_valid && ready_q;

  // A pointer left above a shrunken flow count restarts at flow 0.
  assign rr_flow  = (rr_ptr > number_of_flows) ? '0 : rr_ptr;
  assign tbl_flow = tbl[rpc_conn_id_in[LCONN_TBL-1:0]];

  always_comb begin
    steer_flow = rr_flow;
    unique case (mode_e)
      SteerRR:    steer_flow = rr_flow;
      SteerTable: steer_flow = (tbl_flow > number_of_flows) ? '0 : tbl_flow;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && mode_e == SteerRR) begin
      rr_ptr <= (rr_flow >= number_of_flows) ? '0 : rr_flow + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TBL_N; i++) begin
        tbl[i] <= LMAX_NUM_OF_FLOWS'(i);
      end
    end else if (tbl_wr_en) begin
      tbl[tbl_wr_idx] <= tbl_wr_flow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_q <= '{rpc: rpc_in, flow: FlowId'(steer_flow)};
      end
    end
  end

  // Stage 1 skips the FIFO when it is empty to keep latency at two.
  assign can_pop   = start && ccip_tx_ready;
  assign bypass    = can_pop && fifo_empty && s1_valid;
  assign fifo_pop  = can_pop && !fifo_empty;
  assign fifo_push = s1_valid && !bypass && !fifo_full;
  assign pop_any   = bypass || fifo_pop;
  assign out_data  = bypass ? s1_q : fifo_rdata;

  sync_fifo #(
    .DATA_WIDTH($bits(SteeredRpc)),
    .LOG_DEPTH (LFIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata(s1_q),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Occupancy counts the stage-1 slot so an accepted RPC always fits.
  assign occ   = fifo_count + CW'(s1_valid);
  assign occ_d = occ + CW'(accept) - CW'(pop_any);

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (occ_d < FULL_OCC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpc_out_valid   <= 1'b0;
      rpc_out         <= '0;
      rpc_flow_id_out <= '0;
    end else begin
      rpc_out_valid <= pop_any;
      if (pop_any) begin
        rpc_out         <= out_data.rpc;
        rpc_flow_id_out <= out_data.flow[LMAX_NUM_OF_FLOWS-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else begin
      if (accept) begin
        stat_accepted <= stat_accepted + 32'd1;
      end
      if (start && rpc_in_valid && !ready_q && stat_dropped != '1) begin
        stat_dropped <= stat_dropped + 32'd1;
      end
    end
  end

  assign unused = ^{rpc_conn_id_in, out_data.flow, 32'(NIC_ID)};

endmodule

// File: tb/tb_rpc_flow_steering.sv
// Directed bench for rpc_flow_steering: steering, backpressure,
// table hazards, flow shrink, start gating and reset flush.
module tb_rpc_flow_steering;
  import nic_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b1;
  logic        mode = 1'b0;
  logic [2:0]  number_of_flows = 3'd3;
  logic        tbl_wr_en = 1'b0;
  logic [2:0]  tbl_wr_idx = '0;
  logic [2:0]  tbl_wr_flow = '0;
  RpcIf        rpc_in = '0;
  logic        rpc_in_valid = 1'b0;
  ConnId       rpc_conn_id_in = '0;
  logic        rpc_in_ready;
  logic        ccip_tx_ready = 1'b1;
  RpcIf        rpc_out;
  logic        rpc_out_valid;
  logic [2:0]  rpc_flow_id_out;
  logic [31:0] stat_accepted;
  logic [31:0] stat_dropped;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  RpcIf       q_rpc[$];
  logic [2:0] q_fl[$];
  int         q_cy[$];

  rpc_flow_steering #(
    .NIC_ID(0),
    .LMAX_NUM_OF_FLOWS(3),
    .LCONN_TBL(3),
    .LFIFO_DEPTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .number_of_flows(number_of_flows),
    .tbl_wr_en(tbl_wr_en),
    .tbl_wr_idx(tbl_wr_idx),
    .tbl_wr_flow(tbl_wr_flow),
    .rpc_in(rpc_in),
    .rpc_in_valid(rpc_in_valid),
    .rpc_conn_id_in(rpc_conn_id_in),
    .rpc_in_ready(rpc_in_ready),
    .ccip_tx_ready(ccip_tx_ready),
    .rpc_out(rpc_out),
    .rpc_out_valid(rpc_out_valid),
    .rpc_flow_id_out(rpc_flow_id_out),
    .stat_accepted(stat_accepted),
    .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && rpc_out_valid) begin
      q_rpc.push_back(rpc_out);
      q_fl.push_back(rpc_flow_id_out);
      q_cy.push_back(cyc);
    end
  end

  function automatic RpcIf mk(input logic [15:0] id);
    RpcIf r;
    r.rpc_id = id;
    r.arg = {16'hA5A5, id};
    return r;
  endfunction

  task automatic clear_q();
    q_rpc.delete();
    q_fl.delete();
    q_cy.delete();
  endtask

  task automatic drive(input logic [15:0] id, input ConnId conn);
    rpc_in = mk(id);
    rpc_conn_id_in = conn;
    rpc_in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rpc_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if (rpc_out_valid !== 1'b0 || rpc_out !== '0 || rpc_flow_id_out !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_out got v=%b d=%h f=%0d want 0/0/0",
               rpc_out_valid, rpc_out, rpc_flow_id_out);
    end
    n_cmp++;
    if (stat_accepted !== 32'd0 || stat_dropped !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stats got acc=%0d drop=%0d want 0/0",
               stat_accepted, stat_dropped);
    end
    n_cmp++;
    if (rpc_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", rpc_in_ready);
    end
  endtask

  task automatic test_rr();
    int c0;
    logic [15:0] id;
    clear_q();
    mode = 1'b0;
    number_of_flows = 3'd3;
    c0 = cyc;
    for (int i = 0; i < 8; i++) drive(16'(16'h10 + i), '0);
    idle(6);
    n_cmp++;
    if (q_rpc.size() !== 8) begin
      n_bad++;
      $display("FAIL rr_count got %0d want 8", q_rpc.size());
    end
    for (int i = 0; i < q_rpc.size() && i < 8; i++) begin
      id = 16'(16'h10 + i);
      n_cmp++;
      if (q_rpc[i] !== mk(id) || q_fl[i] !== 3'(i % 4) || q_cy[i] !== c0 + 2 + i) begin
        n_bad++;
        $display("FAIL rr[%0d] got id=%h flow=%0d cyc=%0d want id=%h flow=%0d cyc=%0d",
                 i, q_rpc[i].rpc_id, q_fl[i], q_cy[i], id, i % 4, c0 + 2 + i);
      end
    end
    n_cmp++;
    if (stat_accepted !== 32'd8) begin
      n_bad++;
      $display("FAIL rr_accepted got %0d want 8", stat_accepted);
    end
  endtask

  task automatic test_table();
    clear_q();
    mode = 1'b1;
    tbl_wr_en = 1'b1;
    tbl_wr_idx = 3'd5;
    tbl_wr_flow = 3'd2;
    @(posedge clk);
    #1;
    tbl_wr_idx = 3'd6;
    tbl_wr_flow = 3'd7;
    @(posedge clk);
    #1;
    tbl_wr_en = 1'b0;
    drive(16'h20, 16'h0105);
    drive(16'h21, 16'h0206);
    idle(5);
    n_cmp++;
    if (q_rpc.size() !== 2 || q_fl[0] !== 3'd2 || q_fl[1] !== 3'd0) begin
      n_bad++;
      $display("FAIL table got n=%0d f0=%0d f1=%0d want n=2 f0=2 f1=0",
               q_rpc.size(), q_fl[0], q_fl[1]);
    end
  endtask

  task automatic test_backpressure();
    int c1;
    clear_q();
    mode = 1'b0;
    ccip_tx_ready = 1'b0;
    for (int i = 0; i < 12; i++) drive(16'(16'h30 + i), '0);
    idle(2);
    n_cmp++;
    if (rpc_in_ready !== 1'b0 || q_rpc.size() !== 0) begin
      n_bad++;
      $display("FAIL bp_hold got ready=%b outs=%0d want ready=0 outs=0",
               rpc_in_ready, q_rpc.size());
    end
    n_cmp++;
    if (stat_dropped !== 32'd4 || stat_accepted !== 32'd18) begin
      n_bad++;
      $display("FAIL bp_stats got drop=%0d acc=%0d want drop=4 acc=18",
               stat_dropped, stat_accepted);
    end
    c1 = cyc;
    ccip_tx_ready = 1'b1;
    idle(12);
    n_cmp++;
    if (q_rpc.size() !== 8 || rpc_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_drain got outs=%0d ready=%b want outs=8 ready=1",
               q_rpc.size(), rpc_in_ready);
    end
    for (int i = 0; i < q_rpc.size() && i < 8; i++) begin
      n_cmp++;
      if (q_rpc[i] !== mk(16'(16'h30 + i)) || q_fl[i] !== 3'(i % 4)
          || q_cy[i] !== c1 + 1 + i) begin
        n_bad++;
        $display("FAIL bp[%0d] got id=%h flow=%0d cyc=%0d want id=%h flow=%0d cyc=%0d",
                 i, q_rpc[i].rpc_id, q_fl[i], q_cy[i], 16'h30 + i, i % 4, c1 + 1 + i);
      end
    end
  endtask

  task automatic test_same_cycle();
    clear_q();
    mode = 1'b1;
    tbl_wr_en = 1'b1;
    tbl_wr_idx = 3'd5;
    tbl_wr_flow = 3'd3;
    @(posedge clk);
    #1;
    tbl_wr_flow = 3'd1;
    drive(16'h40, 16'h0005);
    tbl_wr_en = 1'b0;
    drive(16'h41, 16'h0005);
    idle(5);
    n_cmp++;
    if (q_rpc.size() !== 2 || q_fl[0] !== 3'd3 || q_fl[1] !== 3'd1) begin
      n_bad++;
      $display("FAIL wr_lookup got n=%0d f0=%0d f1=%0d want n=2 f0=3 f1=1",
               q_rpc.size(), q_fl[0], q_fl[1]);
    end
  endtask

  task automatic test_shrink();
    logic [2:0] exp_fl [6];
    exp_fl = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0};
    clear_q();
    mode = 1'b0;
    number_of_flows = 3'd3;
    for (int i = 0; i < 3; i++) drive(16'(16'h50 + i), '0);
    number_of_flows = 3'd1;
    for (int i = 3; i < 6; i++) drive(16'(16'h50 + i), '0);
    idle(5);
    n_cmp++;
    if (q_rpc.size() !== 6) begin
      n_bad++;
      $display("FAIL shrink_count got %0d want 6", q_rpc.size());
    end
    for (int i = 0; i < q_rpc.size() && i < 6; i++) begin
      n_cmp++;
      if (q_fl[i] !== exp_fl[i]) begin
        n_bad++;
        $display("FAIL shrink[%0d] got flow=%0d want %0d", i, q_fl[i], exp_fl[i]);
      end
    end
  endtask

  task automatic test_start_low();
    clear_q();
    start = 1'b0;
    drive(16'h60, '0);
    drive(16'h61, '0);
    idle(3);
    n_cmp++;
    if (stat_accepted !== 32'd26 || stat_dropped !== 32'd4 || q_rpc.size() !== 0) begin
      n_bad++;
      $display("FAIL start_low got acc=%0d drop=%0d outs=%0d want 26/4/0",
               stat_accepted, stat_dropped, q_rpc.size());
    end
    start = 1'b1;
    drive(16'h62, '0);
    idle(4);
    n_cmp++;
    if (q_rpc.size() !== 1 || q_fl[0] !== 3'd1 || q_rpc[0] !== mk(16'h62)) begin
      n_bad++;
      $display("FAIL start_resume got n=%0d flow=%0d want n=1 flow=1",
               q_rpc.size(), q_fl[0]);
    end
  endtask

  task automatic test_reset_flush();
    clear_q();
    number_of_flows = 3'd3;
    ccip_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(16'(16'h70 + i), '0);
    idle(1);
    n_cmp++;
    if (q_rpc.size() !== 0 || rpc_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre got outs=%0d ready=%b want 0/1",
               q_rpc.size(), rpc_in_ready);
    end
    reset = 1'b1;
    ccip_tx_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if (rpc_out_valid !== 1'b0 || stat_accepted !== 32'd0 || stat_dropped !== 32'd0) begin
      n_bad++;
      $display("FAIL flush_reset got v=%b acc=%0d drop=%0d want 0/0/0",
               rpc_out_valid, stat_accepted, stat_dropped);
    end
    idle(6);
    n_cmp++;
    if (q_rpc.size() !== 0 || stat_dropped !== 32'd0) begin
      n_bad++;
      $display("FAIL flush_quiet got outs=%0d drop=%0d want 0/0",
               q_rpc.size(), stat_dropped);
    end
    drive(16'h7F, '0);
    idle(4);
    n_cmp++;
    if (q_rpc.size() !== 1 || q_fl[0] !== 3'd0 || stat_accepted !== 32'd1) begin
      n_bad++;
      $display("FAIL flush_rr got n=%0d flow=%0d acc=%0d want 1/0/1",
               q_rpc.size(), q_fl[0], stat_accepted);
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_table();
    test_backpressure();
    test_same_cycle();
    test_shrink();
    test_start_low();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
